ysyx_idu: RTL
=============

YSYX_IDU -- requirements
Module: ysyx_idu

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC width.
REQ-002 SHALL have parameter DATA_W, default 32, instruction and immediate width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port prev_valid  input  1  upstream fetch holds a valid instruction.
REQ-006 SHALL have port ready_o  output  1  this stage accepts an instruction this cycle.
REQ-007 SHALL have port inst  input  DATA_W  fetched instruction word.
REQ-008 SHALL have port pc  input  ADDR_W  PC of inst.
REQ-009 SHALL have port flush  input  1  redirect; discard held and incoming instruction.
REQ-010 SHALL have port next_ready  input  1  downstream execute stage accepts.
REQ-011 SHALL have port valid_o  output  1  decoded payload valid.
REQ-012 SHALL have port inst_o  output  DATA_W  registered instruction word.
REQ-013 SHALL have port pc_o  output  ADDR_W  registered PC.
REQ-014 SHALL have port rd_o, rs1_o, rs2_o  output  5 each  register indices from inst[11:7], [19:15], [24:20].
REQ-015 SHALL have port imm_o  output  DATA_W  sign-extended immediate.
REQ-016 SHALL have port cls_o  output  4  class: 0 OP, 1 OP-IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 SYSTEM, 10 FENCE, 15 ILLEGAL.
REQ-017 SHALL have port funct3_o  output  3  inst[14:12]; alt_o  output  1  inst[30].
REQ-018 SHALL have port wen_o  output  1  rd write enable; illegal_o  output  1  illegal instruction.

Function
REQ-019 Single-entry pipeline register; decode combinational from inst, result registered on accept.
REQ-020 ready_o SHALL equal !valid_o | next_ready (combinational).
REQ-021 Accept when prev_valid & ready_o & !flush; payload registered, valid_o=1 next cycle (latency 1).
REQ-022 valid_o & next_ready & no accept SHALL clear valid_o next cycle.
REQ-023 valid_o & !next_ready SHALL hold every output stable (no payload change).
REQ-024 valid_o & next_ready & accept SHALL load new payload, valid_o stays 1 (back-to-back, one per cycle).
REQ-025 flush SHALL clear valid_o next cycle, overriding simultaneous accept and hold.
REQ-026 Class from inst[6:0]: 0x33,0x13,0x03,0x23,0x63,0x6F,0x67,0x37,0x17,0x73,0x0F; any other value, or inst[1:0]!=2'b11, SHALL be class 15.
REQ-027 imm: I {20{i31},i[31:20]}; S {20{i31},i[31:25],i[11:7]}; B {19{i31},i31,i7,i[30:25],i[11:8],0}; U {i[31:12],12'b0}; J {11{i31},i31,i[19:12],i20,i[30:21],0}; OP/ILLEGAL 0.
REQ-028 wen_o SHALL be 1 for classes 0,1,2,5,6,7,8,9 when rd!=0, else 0.
REQ-029 Class 15 SHALL force illegal_o=1, wen_o=0, imm_o=0; other fields still registered.

Reset
REQ-030 rst SHALL clear valid_o and set inst_o, pc_o, rd_o, rs1_o, rs2_o, imm_o, cls_o, funct3_o, alt_o, wen_o, illegal_o to 0.
REQ-031 rst mid-transfer SHALL drop the held instruction; ready_o=1 in the cycle after reset.

Configuration
REQ-032 Macro YSYX_IDU_RVE_EN defined: any non-illegal instruction whose used rd/rs1/rs2 field has bit 4 set SHALL decode as class 15.
REQ-033 Macro undefined: all 32 register indices legal (RV32I).

Verification
REQ-034 inst=0x00500093, pc=0x80000000, accepted -> next cycle valid_o=1, cls_o=1, rd_o=1, rs1_o=0, imm_o=5, wen_o=1, pc_o=0x80000000.
REQ-035 valid_o=1, next_ready=0, prev_valid=1 new inst -> ready_o=0, all outputs unchanged for 3 cycles; next_ready=1 -> new payload next cycle.
REQ-036 inst=0xFE000EE3 -> cls_o=4, imm_o=0xFFFFFFFC, wen_o=0, funct3_o=0.
REQ-037 flush=1 with prev_valid=1 and valid_o=1 -> valid_o=0 next cycle, no new payload.
REQ-038 inst=0x00000000 -> cls_o=15, illegal_o=1, wen_o=0, imm_o=0.
REQ-039 inst=0x00208833 -> with YSYX_IDU_RVE_EN cls_o=15, illegal_o=1; without cls_o=0, rd_o=16, wen_o=1.

Source files
------------

// File: rtl/ysyx_idu.sv
// rtl/ysyx_idu.sv - RV32I decode stage: single-entry pipeline register with registered decode
// Optional: define YSYX_IDU_RVE_EN to restrict register indices to x0..x15 (RV32E).
module ysyx_idu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prev_valid,
  output logic              ready_o,
  input  logic [DATA_W-1:0] inst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  input  logic              next_ready,
  output logic              valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [4:0]        rd_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [3:0]        cls_o,
  output logic [2:0]        funct3_o,
  output logic              alt_o,
  output logic              wen_o,
  output logic              illegal_o
);

  localparam logic [3:0] CLS_OP     = 4'd0;
  localparam logic [3:0] CLS_OPIMM  = 4'd1;
  localparam logic [3:0] CLS_LOAD   = 4'd2;
  localparam logic [3:0] CLS_STORE  = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_JAL    = 4'd5;
  localparam logic [3:0] CLS_JALR   = 4'd6;
  localparam logic [3:0] CLS_LUI    = 4'd7;
  localparam logic [3:0] CLS_AUIPC  = 4'd8;
  localparam logic [3:0] CLS_SYSTEM = 4'd9;
  localparam logic [3:0] CLS_FENCE  = 4'd10;
  localparam logic [3:0] CLS_ILL    = 4'd15;

  logic [31:0]       ir;
  logic [3:0]        cls_raw;
  logic              rve_bad;
  logic [3:0]        cls_d;
  logic [31:0]       imm32;
  logic [DATA_W-1:0] imm_d;
  logic              wen_d;
  logic              illegal_d;
  logic              accept;

  logic              valid_q;
  logic [DATA_W-1:0] inst_q;
  logic [ADDR_W-1:0] pc_q;
  logic [4:0]        rd_q, rs1_q, rs2_q;
  logic [DATA_W-1:0] imm_q;
  logic [3:0]        cls_q;
  logic [2:0]        funct3_q;
  logic              alt_q, wen_q, illegal_q;

  assign ir = inst[31:0];

  always_comb begin
    cls_raw = CLS_ILL;
    case (ir[6:0])
      7'h33:   cls_raw = CLS_OP;
      7'h13:   cls_raw = CLS_OPIMM;
      7'h03:   cls_raw = CLS_LOAD;
      7'h23:   cls_raw = CLS_STORE;
      7'h63:   cls_raw = CLS_BRANCH;
      7'h6F:   cls_raw = CLS_JAL;
      7'h67:   cls_raw = CLS_JALR;
      7'h37:   cls_raw = CLS_LUI;
      7'h17:   cls_raw = CLS_AUIPC;
      7'h73:   cls_raw = CLS_SYSTEM;
      7'h0F:   cls_raw = CLS_FENCE;
      default: cls_raw = CLS_ILL;
    endcase
  end

`ifdef YSYX_IDU_RVE_EN
  // Only the register fields a class actually reads or writes are range-checked.
  always_comb begin
    rve_bad = 1'b0;
    case (cls_raw)
      CLS_OP:                                   rve_bad = ir[11] | ir[19] | ir[24];
      CLS_OPIMM, CLS_LOAD, CLS_JALR, CLS_SYSTEM: rve_bad = ir[11] | ir[19];
      CLS_STORE, CLS_BRANCH:                    rve_bad = ir[19] | ir[24];
      CLS_JAL, CLS_LUI, CLS_AUIPC:              rve_bad = ir[11];
      default:                                  rve_bad = 1'b0;
    endcase
  end
`else
  assign rve_bad = 1'b0;
`endif

  assign cls_d     = rve_bad ? CLS_ILL : cls_raw;
  assign illegal_d = (cls_d == CLS_ILL);

  always_comb begin
    imm32 = 32'd0;
    case (cls_d)
      CLS_OPIMM, CLS_LOAD, CLS_JALR, CLS_SYSTEM, CLS_FENCE:
        imm32 = {{20{ir[31]}}, ir[31:20]};
      CLS_STORE:
        imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      CLS_BRANCH:
        imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      CLS_LUI, CLS_AUIPC:
        imm32 = {ir[31:12], 12'd0};
      CLS_JAL:
        imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:
        imm32 = 32'd0;
    endcase
  end

  assign imm_d = DATA_W'($signed(imm32));

  always_comb begin
    wen_d = 1'b0;
    case (cls_d)
      CLS_OP, CLS_OPIMM, CLS_LOAD, CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_SYSTEM:
        wen_d = (ir[11:7] != 5'd0);
      default:
        wen_d = 1'b0;
    endcase
  end

  assign ready_o = !valid_q || next_ready;
  assign accept  = prev_valid && ready_o && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      inst_q    <= '0;
      pc_q      <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      cls_q     <= '0;
      funct3_q  <= '0;
      alt_q     <= 1'b0;
      wen_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      // Flush wins over both accept and hold; payload only moves on accept.
      if (flush)           valid_q <= 1'b0;
      else if (accept)     valid_q <= 1'b1;
      else if (next_ready) valid_q <= 1'b0;
      if (accept) begin
        inst_q    <= inst;
        pc_q      <= pc;
        rd_q      <= ir[11:7];
        rs1_q     <= ir[19:15];
        rs2_q     <= ir[24:20];
        imm_q     <= imm_d;
        cls_q     <= cls_d;
        funct3_q  <= ir[14:12];
        alt_q     <= ir[30];
        wen_q     <= wen_d;
        illegal_q <= illegal_d;
      end
    end
  end

  assign valid_o   = valid_q;
  assign inst_o    = inst_q;
  assign pc_o      = pc_q;
  assign rd_o      = rd_q;
  assign rs1_o     = rs1_q;
  assign rs2_o     = rs2_q;
  assign imm_o     = imm_q;
  assign cls_o     = cls_q;
  assign funct3_o  = funct3_q;
  assign alt_o     = alt_q;
  assign wen_o     = wen_q;
  assign illegal_o = illegal_q;

endmodule
